// File: rtl/cordic_pkg.sv
// Shared constants and tag layout for the Cordic sharing front end.
// The flip field exists only when CORDIC_ARB_QUADRANT_EN is defined.
package cordic_pkg;

  localparam int unsigned DEF_WIDTH            = 16;
  localparam int unsigned DEF_AWIDTH           = 16;
  localparam int unsigned DEF_EXTEND_PRECISION = 4;
  localparam int unsigned DEF_PIPELINE         = 15;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  localparam logic [DEF_AWIDTH-1:0] ANGLE_PI = 1 << (DEF_AWIDTH - 1);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
`ifdef CORDIC_ARB_QUADRANT_EN
    logic                flip;
`endif
  } tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner whenever the grant is taken.
module cordic_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_grant_valid
);

  localparam int unsigned CandW = ID_W + 1;

  logic [ID_W-1:0]  r_ptr;
  logic [CandW-1:0] w_cand;

  // Walk from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + CandW'(k);
      if (w_cand >= CandW'(NUM_REQ)) begin
        w_cand = w_cand - CandW'(NUM_REQ);
      end
      if (i_req[w_cand[ID_W-1:0]]) begin
        o_grant_idx   = w_cand[ID_W-1:0];
        o_grant_valid = 1'b1;
      end
    end
  end

  assign o_grant_oh = o_grant_valid ? (NUM_REQ'(1) << o_grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined Cordic vectoring core between NUM_REQ requesters with a tag pipe.
// Define CORDIC_ARB_QUADRANT_EN to accept signed X (left half-plane folded, angle + pi).
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned WIDTH            = DEF_WIDTH,
  parameter int unsigned AWIDTH           = DEF_AWIDTH,
  parameter int unsigned EXTEND_PRECISION = DEF_EXTEND_PRECISION,
  parameter int unsigned PIPELINE         = DEF_PIPELINE,
  localparam int unsigned IdW             = $clog2(NUM_REQ),
  localparam int unsigned OccW            = $clog2(PIPELINE + 1),
  localparam int unsigned RW              = WIDTH + EXTEND_PRECISION
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic                     cordic_ena,
  output logic [WIDTH-1:0]         cordic_xi,
  output logic [WIDTH-1:0]         cordic_yi,
  input  logic [RW-1:0]            cordic_r,
  input  logic [AWIDTH-1:0]        cordic_a,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [RW-1:0]            rsp_r,
  output logic [AWIDTH-1:0]        rsp_a,
  output logic [OccW-1:0]          occupancy,
  output logic                     busy
);

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [IdW-1:0]     w_grant_idx;
  logic               w_grant_valid;
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;

  tag_t               r_tag [PIPELINE];
  tag_t               w_tail;
  tag_t               w_issue_tag;
  logic               w_tail_valid;
  logic [IdW-1:0]     w_tail_id;
  logic               w_unused_id;
  logic               w_stall;
  logic               w_issue;
  logic               w_retire;
  logic [OccW-1:0]    r_occ;

  cordic_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IdW)
  ) u_rr_arbiter (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req_valid),
    .i_advance     (w_issue),
    .o_grant_oh    (w_grant_oh),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Tail bookkeeping; gated by rst_n so nothing stale is presented while in reset.
  assign w_tail       = r_tag[PIPELINE-1];
  assign w_tail_valid = w_tail.valid & rst_n;
  assign w_tail_id    = w_tail.id[IdW-1:0];
  assign w_unused_id  = ^w_tail.id;

  assign w_stall    = w_tail_valid & ~rsp_ready[w_tail_id];
  assign cordic_ena = ~w_stall;
  assign w_issue    = w_grant_valid & cordic_ena & rst_n;
  assign w_retire   = w_tail_valid & rsp_ready[w_tail_id];

  assign req_ready = w_grant_oh & {NUM_REQ{cordic_ena & rst_n}};

  assign w_x = w_grant_valid ? req_x[w_grant_idx*WIDTH +: WIDTH] : '0;
  assign w_y = w_grant_valid ? req_y[w_grant_idx*WIDTH +: WIDTH] : '0;

`ifdef CORDIC_ARB_QUADRANT_EN
  localparam logic [WIDTH-1:0]  SMin    = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [AWIDTH-1:0] AnglePi = {1'b1, {(AWIDTH - 1){1'b0}}};

  logic w_flip;

  // Left half-plane operands are rotated by pi; -y saturates so it stays representable.
  assign w_flip    = w_x[WIDTH-1];
  assign cordic_xi = w_flip ? -w_x : w_x;
  assign cordic_yi = w_flip ? ((w_y == SMin) ? ~SMin : -w_y) : w_y;
  assign rsp_a     = w_tail.flip ? cordic_a + AnglePi : cordic_a;
`else
  assign cordic_xi = w_x;
  assign cordic_yi = w_y;
  assign rsp_a     = cordic_a;
`endif

  always_comb begin
    w_issue_tag       = '0;
    w_issue_tag.valid = w_issue;
    w_issue_tag.id    = TAG_ID_W'(w_grant_idx);
`ifdef CORDIC_ARB_QUADRANT_EN
    w_issue_tag.flip  = w_flip;
`endif
  end

  assign rsp_valid = w_tail_valid ? (NUM_REQ'(1) << w_tail_id) : '0;
  assign rsp_r     = cordic_r;

  // Tag pipe moves in lockstep with the core; frozen in place while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPELINE; i++) begin
        r_tag[i] <= '0;
      end
    end else if (cordic_ena) begin
      r_tag[0] <= w_issue_tag;
      for (int i = 1; i < PIPELINE; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (w_issue && !w_retire) begin
      r_occ <= r_occ + OccW'(1);
    end else if (!w_issue && w_retire) begin
      r_occ <= r_occ - OccW'(1);
    end
  end

  assign occupancy = r_occ;
  assign busy      = (r_occ != '0);

endmodule
